// File: rtl/button_events.sv
// button_events: converts a debounced, synchronous button level into
// press / release / long-press / auto-repeat event pulses, a "held" level
// and a saturating count of repeat pulses since the last press.
module button_events #(
  parameter int p_counter_width = 8,
  parameter int p_long_count    = 200,
  parameter int p_repeat_count  = 50
) (
  input  logic       i_w_clk,
  input  logic       i_w_reset,
  input  logic       i_w_level,
  input  logic       i_w_enable,
  output logic       o_w_press,
  output logic       o_w_release,
  output logic       o_w_long,
  output logic       o_w_repeat,
  output logic       o_w_held,
  output logic [7:0] o_w_repeats
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    REPEAT  = 2'd2
  } state_t;

  localparam logic [p_counter_width-1:0] long_last   = p_counter_width'(p_long_count - 1);
  localparam logic [p_counter_width-1:0] repeat_last = p_counter_width'(p_repeat_count - 1);

  state_t                     state, state_nxt;
  logic [p_counter_width-1:0] counter, counter_nxt;
  logic                       prev_level;
  logic                       press_nxt, release_nxt, long_nxt, repeat_nxt, held_nxt;
  logic [7:0]                 repeats_nxt;

  // Previous-level flop: tracks the input every edge regardless of enable or state.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) prev_level <= 1'b0;
    else           prev_level <= i_w_level;
  end

  // State, hold counter and all outputs are registered together.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state       <= IDLE;
      counter     <= '0;
      o_w_press   <= 1'b0;
      o_w_release <= 1'b0;
      o_w_long    <= 1'b0;
      o_w_repeat  <= 1'b0;
      o_w_held    <= 1'b0;
      o_w_repeats <= '0;
    end else begin
      state       <= state_nxt;
      counter     <= counter_nxt;
      o_w_press   <= press_nxt;
      o_w_release <= release_nxt;
      o_w_long    <= long_nxt;
      o_w_repeat  <= repeat_nxt;
      o_w_held    <= held_nxt;
      o_w_repeats <= repeats_nxt;
    end
  end

  // Next-state and next-output logic; release is checked before any
  // threshold so a fall on a threshold edge yields only the release pulse.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    repeats_nxt = o_w_repeats;

    if (!i_w_enable) begin
      state_nxt   = IDLE;
      counter_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_w_level && !prev_level) begin
            state_nxt   = PRESSED;
            counter_nxt = '0;
            repeats_nxt = '0;
            press_nxt   = 1'b1;
          end
        end
        PRESSED: begin
          if (!i_w_level) begin
            state_nxt   = IDLE;
            counter_nxt = '0;
            release_nxt = 1'b1;
          end else if (counter == long_last) begin
            state_nxt   = REPEAT;
            counter_nxt = '0;
            long_nxt    = 1'b1;
          end else begin
            counter_nxt = counter + 1'b1;
          end
        end
        REPEAT: begin
          if (!i_w_level) begin
            state_nxt   = IDLE;
            counter_nxt = '0;
            release_nxt = 1'b1;
          end else if (counter == repeat_last) begin
            counter_nxt = '0;
            repeat_nxt  = 1'b1;
            if (o_w_repeats != 8'hFF) repeats_nxt = o_w_repeats + 8'd1;
          end else begin
            counter_nxt = counter + 1'b1;
          end
        end
        default: begin
          state_nxt   = IDLE;
          counter_nxt = '0;
        end
      endcase
    end

    held_nxt = (state_nxt == REPEAT);
  end

endmodule

// File: doc/button_events.md
BUTTON_EVENTS -- requirements
Module: button_events

Interface
REQ-001 SHALL have parameter p_counter_width, default 8: width of the hold-time counter.
REQ-002 SHALL have parameter p_long_count, default 200: cycles held before long-press; legal range 1..2^p_counter_width-1.
REQ-003 SHALL have parameter p_repeat_count, default 50: cycles between auto-repeat pulses; legal range 1..2^p_counter_width-1.
REQ-004 SHALL have port i_w_clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_w_reset, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port i_w_level, input, 1: debounced button level, already synchronous to i_w_clk, 1 = pressed.
REQ-007 SHALL have port i_w_enable, input, 1: event generation enable.
REQ-008 SHALL have port o_w_press, output, 1: one-cycle pulse on press.
REQ-009 SHALL have port o_w_release, output, 1: one-cycle pulse on release.
REQ-010 SHALL have port o_w_long, output, 1: one-cycle pulse when hold reaches p_long_count.
REQ-011 SHALL have port o_w_repeat, output, 1: one-cycle pulse every p_repeat_count cycles after long-press.
REQ-012 SHALL have port o_w_held, output, 1: level, high while in REPEAT state.
REQ-013 SHALL have port o_w_repeats, output, 8: repeat pulses issued since last press, saturating.

Function
REQ-014 SHALL register i_w_level every edge into a previous-level flop, independent of i_w_enable and state.
REQ-015 SHALL implement FSM states IDLE, PRESSED, REPEAT; all outputs registered (driven from flops only).
REQ-016 SHALL, in IDLE with enable=1, on an edge sampling level=1 and previous=0: go PRESSED, clear counter, clear o_w_repeats, assert o_w_press for the following cycle (latency 1 cycle).
REQ-017 SHALL, in PRESSED with level=1: if counter == p_long_count-1, assert o_w_long, go REPEAT, clear counter; else counter+1. o_w_long therefore follows press edge by exactly p_long_count edges.
REQ-018 SHALL, in REPEAT with level=1: if counter == p_repeat_count-1, assert o_w_repeat, clear counter, increment o_w_repeats saturating at 255; else counter+1.
REQ-019 SHALL, in PRESSED or REPEAT on an edge sampling level=0: assert o_w_release for the following cycle, go IDLE, clear counter; o_w_repeats holds its value.
REQ-020 SHALL give release priority on a simultaneous threshold edge: o_w_release only, no o_w_long/o_w_repeat, no o_w_repeats increment.
REQ-021 SHALL, on any edge with enable=0: go IDLE, clear counter, drive all pulses 0, with no o_w_release issued.
REQ-022 SHALL not report a press when enable rises while level is already 1; a new 0->1 transition is required.
REQ-023 SHALL, in IDLE, ignore level=1 with previous=1 and never pulse o_w_release.
REQ-024 SHALL keep every pulse output high for exactly one cycle; no two of press/long/repeat/release are high in the same cycle.
REQ-025 SHALL keep o_w_held equal to (state == REPEAT), updated on the same edge as the state.

Reset
REQ-026 SHALL, while i_w_reset=1 (asynchronous, no clock needed): state IDLE, counter 0, previous-level 0, o_w_press/o_w_release/o_w_long/o_w_repeat/o_w_held 0, o_w_repeats 0.
REQ-027 SHALL report a press on the first edge after reset release if level=1 then (previous-level resets to 0).
REQ-028 SHALL abort any in-progress hold on reset assertion mid-operation, with no release pulse.

Verification (p_counter_width=4, p_long_count=4, p_repeat_count=2)
REQ-029 SHALL cover: level 0->1 at edge E, held 3 edges, then 0 -> press cycle after E, release cycle after E+3, no long.
REQ-030 SHALL cover: level held 1 for 10 edges from E -> press at E+1, long at E+5, repeats at E+7 and E+9, o_w_held=1 from E+5, o_w_repeats=2.
REQ-031 SHALL cover: level falls exactly at edge E+4 -> release only, o_w_long never asserted.
REQ-032 SHALL cover: enable dropped at E+2 while held, re-raised at E+6 with level still 1 -> no release, no new press, outputs 0 until level cycles 0->1.
REQ-033 SHALL cover: reset asserted between edges during REPEAT -> all outputs 0 immediately, o_w_repeats=0; level held 1 through deassert -> press on next edge.
REQ-034 SHALL cover: hold for 600 edges -> o_w_repeats saturates at 255 and stays at 255 while repeats continue.
